serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing d = a - b - bin, LSB first, one bit per clock.
- Internally one full-subtractor cell (d = a^b^br; borrow = (b&br)|(~a&b)|(~a&br)) plus a registered borrow.
- Sits in the arithmetic datapath where area matters more than latency; start/busy/done handshake with the controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured when start is accepted
- b  input  WIDTH  subtrahend, captured when start is accepted
- bin  input  1  borrow-in, captured when start is accepted
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when the result is valid
- d  output  WIDTH  difference; holds the last result
- bout  output  1  borrow-out of the MSB; holds the last result

Behaviour:
- Reset: asserting rst_n=0 takes effect immediately, with no clock needed.
  - State goes to IDLE; busy=0, done=0, d=0, bout=0.
  - Internal shift registers, borrow register and counter are all cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On a clk edge with start=1 (edge E0): load a_sr<=a, b_sr<=b, br<=bin, cnt<=0; next state SHIFT.
  - start=0: remain in IDLE.
- SHIFT (busy=1):
  - Each edge: compute the bit from a_sr[0], b_sr[0], br.
  - Shift the difference bit into the MSB of r_sr; shift a_sr and b_sr right by 1.
  - br <= new borrow; cnt <= cnt+1.
- SHIFT exit, at the edge processing bit WIDTH-1 (edge E_WIDTH):
  - d <= final r_sr value (including this bit); bout <= final borrow.
  - done <= 1; busy <= 0; next state DONE.
- DONE: lasts exactly one cycle with done=1; the next edge clears done and returns to IDLE.
- Latency:
  - Start accepted at E0; done high during the cycle after E_WIDTH.
  - The next start can be accepted at E_WIDTH+2 at the earliest.
  - Throughput: one operation per WIDTH+2 cycles.
- d and bout change only on completion; during SHIFT they hold the previous result.
- start while in SHIFT or DONE: ignored, no queuing. Operands on a/b/bin may change freely after E0.
- start held high continuously: a new operation is accepted at every IDLE visit.
- Wrap-around: the result is modulo 2^WIDTH; bout=1 iff a < b + bin (unsigned).
- Reset mid-operation: the operation is aborted and no done pulse occurs; all outputs take their reset values.
- cnt width is clog2(WIDTH)+1 bits; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), signed two's-complement overflow of a - b - bin.
  - ovf = (borrow into MSB) XOR (borrow out of MSB); the borrow into the MSB is captured at the last SHIFT step.
  - Updated together with d and bout; reset value 0; holds between operations.
- Not defined: no ovf port and no extra registers; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start pulse -> busy for 8 cycles; done pulse at cycle 9 after E0; d=0x1E, bout=0.
- a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1. a=0x10, b=0x0F, bin=1 -> d=0x00, bout=0.
- With SERIAL_SUB_OVF_EN:
  - a=0x80, b=0x01 -> d=0x7F, bout=0, ovf=1.
  - a=0x7F, b=0xFF -> d=0x80, bout=1, ovf=1.
  - a=0x05, b=0x03 -> ovf=0.
- start re-pulsed at cycles 3 and 8 of an operation (a=0x5A, b=0x3C) -> ignored; a single done; d=0x1E. Then start held high -> back-to-back results every 10 cycles.
- Operation a=0x33, b=0x11 completed (d=0x22); new operation started, then rst_n=0 at SHIFT cycle 4, asynchronously between edges -> d=0, bout=0, busy=0 immediately; no done pulse. After release, start with a=0x01, b=0x01 -> d=0x00.
- 1000 random a, b, bin with random start gaps -> each d/bout matches (a - b - bin) mod 256 and the borrow; d unchanged during busy.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: d = a - b - bin, LSB first, one bit per clock.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Handshake: start is accepted only in IDLE (busy=0, done=0); busy is high for
  // exactly WIDTH cycles, then done pulses for one cycle with d/bout valid.
  // start seen while busy or done is dropped, never queued.

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             diff_bit;
  logic             borrow_bit;
  logic             last_bit;

  // Single full-subtractor cell operating on the current LSBs.
  assign diff_bit   = a_sr[0] ^ b_sr[0] ^ br;
  assign borrow_bit = (b_sr[0] & br) | (~a_sr[0] & b_sr[0]) | (~a_sr[0] & br);
  assign last_bit   = (cnt == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      d    <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      if (state == IDLE && start) begin
        a_sr <= a;
        b_sr <= b;
        br   <= bin;
        cnt  <= '0;
      end else if (state == SHIFT) begin
        a_sr <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr <= {1'b0, b_sr[WIDTH-1:1]};
        r_sr <= {diff_bit, r_sr[WIDTH-1:1]};
        br   <= borrow_bit;
        cnt  <= cnt + 1'b1;
        // Results publish only on the final bit so d/bout hold during SHIFT.
        if (last_bit) begin
          d    <= {diff_bit, r_sr[WIDTH-1:1]};
          bout <= borrow_bit;
`ifdef SERIAL_SUB_OVF_EN
          ovf  <= br ^ borrow_bit;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: timeline/arithmetic reference model,
// per-cycle compare, literal directed cases, reset abort and random operations.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         bin   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int tests = 0;
  int fails = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Plain arithmetic reference for one operation.
  function automatic void sub_ref(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c, output logic [W-1:0] dd,
                                  output logic bb, output logic oo);
    longint diff;
    longint sx;
    longint sy;
    longint sr;
    diff = longint'(x) - longint'(y) - longint'(c);
    dd   = diff[W-1:0];
    bb   = (diff < 0);
    sx   = x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
    sy   = y[W-1] ? longint'(y) - (longint'(1) << W) : longint'(y);
    sr   = sx - sy - longint'(c);
    oo   = (sr < -(longint'(1) << (W - 1))) || (sr > (longint'(1) << (W - 1)) - 1);
  endfunction

  // Reference model: operation timeline plus expected-result queue.
  logic [W+1:0] exp_q[$];
  bit           m_active = 0;
  int           m_rel    = 0;
  logic         m_busy   = 0;
  logic         m_done   = 0;
  logic [W-1:0] m_d      = '0;
  logic         m_bout   = 0;
  logic         m_ovf    = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] rd;
    logic         rb;
    logic         ro;
    logic [W+1:0] e;
    if (!rst_n) begin
      m_active = 0; m_rel = 0; m_busy = 0; m_done = 0;
      m_d = '0; m_bout = 0; m_ovf = 0;
      exp_q.delete();
    end else if (!m_active) begin
      m_done = 0;
      if (start) begin
        sub_ref(a, b, bin, rd, rb, ro);
        exp_q.push_back({ro, rb, rd});
        m_active = 1;
        m_rel    = 0;
        m_busy   = 1;
      end
    end else begin
      m_rel++;
      m_busy = (m_rel < W);
      m_done = (m_rel == W);
      if (m_rel == W && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_d    = e[W-1:0];
        m_bout = e[W];
        m_ovf  = e[W+1];
      end
      if (m_rel == W + 1) m_active = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("d", 32'(d), 32'(m_d));
      check("bout", 32'(bout), 32'(m_bout));
`ifdef SERIAL_SUB_OVF_EN
      check("ovf", 32'(ovf), 32'(m_ovf));
`endif
    end
  end

  // One operation from IDLE; operands are scrambled after acceptance.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                        output bit seen, output int done_at, output int busy_cyc);
    @(posedge clk); #1;
    a = ai; b = bi; bin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    seen = 0; done_at = -1; busy_cyc = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin seen = 1; done_at = i; end
    end
  endtask

  task automatic op_lit(input string nm, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic ci, input logic [W-1:0] ed, input logic eb);
    bit seen;
    int done_at;
    int busy_cyc;
    run_op(ai, bi, ci, seen, done_at, busy_cyc);
    check({nm, "_done_seen"}, 32'(seen), 32'd1);
    check({nm, "_done_cycle"}, 32'(done_at), 32'(W + 1));
    check({nm, "_busy_cycles"}, 32'(busy_cyc), 32'(W));
    check({nm, "_d"}, 32'(d), 32'(ed));
    check({nm, "_bout"}, 32'(bout), 32'(eb));
  endtask

  initial begin
    bit seen;
    int done_at;
    int busy_cyc;
    int ndone;
    int last;
    int cyc;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    #10 rst_n = 1'b1;

    op_lit("t5a3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    op_lit("t0001", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    op_lit("t100f", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    op_lit("t8001", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
    check("t8001_ovf", 32'(ovf), 32'd1);
    op_lit("t7fff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1);
    check("t7fff_ovf", 32'(ovf), 32'd1);
    op_lit("t0503", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    check("t0503_ovf", 32'(ovf), 32'd0);
`endif

    // start re-pulsed during SHIFT must be ignored.
    @(posedge clk); #1;
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
      start = (i == 3 || i == 8);
    end
    check("repulse_done_count", 32'(ndone), 32'd1);
    check("repulse_d", 32'(d), 32'h1E);

    // start held high: one result every W+2 cycles.
    @(posedge clk); #1;
    a = 8'h21; b = 8'h10; bin = 1'b0; start = 1'b1;
    ndone = 0; last = -1; cyc = 0;
    for (int i = 0; i < 60 && ndone < 3; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (ndone > 0) check("b2b_period", 32'(cyc - last), 32'(W + 2));
        last = cyc;
        ndone++;
      end
    end
    check("b2b_count", 32'(ndone), 32'd3);
    check("b2b_d", 32'(d), 32'h11);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (W + 3) @(posedge clk);

    // Asynchronous reset in the middle of an operation.
    op_lit("t3311", 8'h33, 8'h11, 1'b0, 8'h22, 1'b0);
    @(posedge clk); #1;
    a = 8'hC3; b = 8'h42; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_d", 32'(d), 32'd0);
    check("arst_bout", 32'(bout), 32'd0);
    ndone = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("arst_no_done", 32'(ndone), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    op_lit("t0101", 8'h01, 8'h01, 1'b0, 8'h00, 1'b0);

    // Random operations with random idle gaps; the per-cycle compare checks them.
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_op(W'($urandom), W'($urandom), 1'($urandom), seen, done_at, busy_cyc);
      if (!seen) begin
        check("rand_done_timeout", 32'(seen), 32'd1);
        break;
      end
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
